// File: rtl/led_cube_pkg.sv
// Shared constants and types for the LED cube streaming frame buffer.
// Holds the default frame geometry, the derived pointer widths and the
// receive-stream FSM state encoding.
package led_cube_pkg;

  localparam int unsigned FRAME_BYTES = 64;
  localparam int unsigned NUM_FRAMES  = 8;
  localparam int unsigned ROW_W       = $clog2(FRAME_BYTES);
  localparam int unsigned SLOT_W      = $clog2(NUM_FRAMES);
  localparam int unsigned DATA_W      = 8;

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    FILL = 1'b1
  } stream_state_e;

endpackage

// File: rtl/led_cube_frame_ram.sv
// Simple dual-port frame memory: one synchronous write port and one
// registered read port (read-before-write on address collision).
// Ports:
//   clk, rst            clock; rst clears only the read data register
//   i_we/i_waddr/i_wdata write strobe, address, data
//   i_raddr             read address, sampled every cycle
//   o_rd_data           registered read data
module led_cube_frame_ram #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  // Memory array: no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Output register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[i_raddr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/led_cube_stream_buffer.sv
// Receive-side frame buffer for streaming mode. Assembles SOF-delimited
// byte streams into fixed-size frames in a ring of slots and exposes the
// oldest complete frame through a registered random-access read port.
// Ports:
//   clk, rst, flush      clock, sync reset, sync pointer/FSM clear
//   in_valid/in_data/in_sof/in_ready  byte stream input with handshake
//   rd_addr/rd_data     head-frame read port, one cycle latency
//   frame_avail/frame_pop/occupancy   head-frame status and release
//   err_sof             one-cycle pulse when a partial frame is abandoned
module led_cube_stream_buffer
  import led_cube_pkg::*;
#(
  parameter int unsigned FRAME_BYTES = led_cube_pkg::FRAME_BYTES,
  parameter int unsigned NUM_FRAMES  = led_cube_pkg::NUM_FRAMES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_sof,
  output logic                          in_ready,
  input  logic [$clog2(FRAME_BYTES)-1:0] rd_addr,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          frame_avail,
  input  logic                          frame_pop,
  output logic [$clog2(NUM_FRAMES):0]   occupancy,
  output logic                          err_sof
);

  localparam int unsigned ROW_BITS  = $clog2(FRAME_BYTES);
  localparam int unsigned SLOT_BITS = $clog2(NUM_FRAMES);
  localparam int unsigned OCC_BITS  = SLOT_BITS + 1;
  localparam int unsigned ADDR_BITS = SLOT_BITS + ROW_BITS;
  localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(FRAME_BYTES - 1);
  localparam logic [OCC_BITS-1:0] FULL_OCC = OCC_BITS'(NUM_FRAMES);

  stream_state_e        r_state;
  stream_state_e        w_state_nxt;
  logic [ROW_BITS-1:0]  r_wr_row;
  logic [ROW_BITS-1:0]  w_wr_row_nxt;
  logic [ROW_BITS-1:0]  w_wr_addr_row;
  logic [SLOT_BITS-1:0] r_head;
  logic [SLOT_BITS-1:0] r_tail;
  logic [OCC_BITS-1:0]  r_occupancy;
  logic                 r_err_sof;
  logic                 w_accept;
  logic                 w_we;
  logic                 w_commit;
  logic                 w_abandon;
  logic                 w_pop;
  logic                 w_ram_we;

  assign in_ready    = (r_occupancy != FULL_OCC);
  assign frame_avail = (r_occupancy != '0);
  assign occupancy   = r_occupancy;
  assign err_sof     = r_err_sof;

  assign w_accept = in_valid && in_ready;
  assign w_pop    = frame_pop && (r_occupancy != '0);

  // Stream FSM: next state, write row and commit/abandon strobes.
  always_comb begin
    w_state_nxt   = r_state;
    w_wr_row_nxt  = r_wr_row;
    w_wr_addr_row = r_wr_row;
    w_we          = 1'b0;
    w_commit      = 1'b0;
    w_abandon     = 1'b0;
    unique case (r_state)
      HUNT: begin
        if (w_accept && in_sof) begin
          w_we          = 1'b1;
          w_wr_addr_row = '0;
          w_wr_row_nxt  = ROW_BITS'(1);
          w_state_nxt   = FILL;
        end
      end
      FILL: begin
        if (w_accept) begin
          w_we = 1'b1;
          if (in_sof && (r_wr_row != '0)) begin
            // Restart in the same tail slot; the partial frame is overwritten.
            w_abandon     = 1'b1;
            w_wr_addr_row = '0;
            w_wr_row_nxt  = ROW_BITS'(1);
          end else if (r_wr_row == LAST_ROW) begin
            w_commit     = 1'b1;
            w_wr_row_nxt = '0;
            w_state_nxt  = HUNT;
          end else begin
            w_wr_row_nxt = r_wr_row + 1'b1;
          end
        end
      end
      default: w_state_nxt = HUNT;
    endcase
  end

  // Pointer, occupancy and FSM state registers.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state     <= HUNT;
      r_wr_row    <= '0;
      r_head      <= '0;
      r_tail      <= '0;
      r_occupancy <= '0;
      r_err_sof   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wr_row  <= w_wr_row_nxt;
      r_err_sof <= w_abandon;
      if (w_commit) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      // Simultaneous commit and pop leaves occupancy unchanged.
      unique case ({w_commit, w_pop})
        2'b10:   r_occupancy <= r_occupancy + 1'b1;
        2'b01:   r_occupancy <= r_occupancy - 1'b1;
        default: r_occupancy <= r_occupancy;
      endcase
    end
  end

  // Reset and flush block any write issued in the same cycle.
  assign w_ram_we = w_we && !rst && !flush;

  led_cube_frame_ram #(
    .ADDR_W (ADDR_BITS),
    .DATA_W (DATA_W)
  ) u_frame_ram (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_ram_we),
    .i_waddr   ({r_tail, w_wr_addr_row}),
    .i_wdata   (in_data),
    .i_raddr   ({r_head, rd_addr}),
    .o_rd_data (rd_data)
  );

endmodule

// File: tb/tb_led_cube_stream_buffer.sv
// Self-checking bench for led_cube_stream_buffer: a table of frame records
// drives the fill phase, hand-written sequences cover full/pop, commit with
// pop, flush and reset; read data goes through an expected-value queue.
module tb_led_cube_stream_buffer;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_sof;
  logic       in_ready;
  logic [5:0] rd_addr;
  logic [7:0] rd_data;
  logic       frame_avail;
  logic       frame_pop;
  logic [3:0] occupancy;
  logic       err_sof;

  int         n_vec;
  int         n_miss;
  int         err_cnt;
  logic [7:0] exp_q[$];
  logic       rd_issue;
  logic       chk_pending;

  typedef struct {
    logic [7:0] seed;
    int         junk;
    int         abandon;
    int         exp_occ;
    logic       exp_ready;
    int         exp_err;
  } vec_t;

  vec_t vecs [8];

  led_cube_stream_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_sof      (in_sof),
    .in_ready    (in_ready),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_avail (frame_avail),
    .frame_pop   (frame_pop),
    .occupancy   (occupancy),
    .err_sof     (err_sof)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Read data scoreboard and err_sof pulse counter.
  always @(posedge clk) chk_pending = rd_issue;

  always @(negedge clk) begin
    logic [7:0] e;
    if (chk_pending) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'(exp_q.size()), 1);
      end else begin
        e = exp_q.pop_front();
        check("rd_data", rd_data, e);
      end
    end
    if (err_sof === 1'b1) err_cnt++;
  end

  task automatic send_byte(input logic [7:0] d, input logic s);
    logic acc;
    int   tries;
    acc = 1'b0;
    tries = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = s;
    while (!acc && tries < 100) begin
      acc = in_ready;
      @(negedge clk);
      tries++;
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    if (!acc) check("send_timeout", acc, 1);
  endtask

  task automatic send_frame(input logic [7:0] seed);
    for (int i = 0; i < 64; i++) send_byte(8'(seed + i), (i == 0));
  endtask

  task automatic send_partial(input int n);
    for (int i = 0; i < n; i++) send_byte(8'hEE, (i == 0));
  endtask

  task automatic send_junk(input int n);
    for (int i = 0; i < n; i++) send_byte(8'hAA, 1'b0);
  endtask

  task automatic pop_head();
    frame_pop = 1'b1;
    @(negedge clk);
    frame_pop = 1'b0;
  endtask

  task automatic read_frame(input logic [7:0] seed);
    for (int a = 0; a < 64; a++) begin
      rd_addr  = 6'(a);
      rd_issue = 1'b1;
      exp_q.push_back(8'(seed + a));
      @(negedge clk);
    end
    rd_issue = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("sb_drain", 32'(exp_q.size()), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    n_vec = 0; n_miss = 0; err_cnt = 0;
    rd_issue = 1'b0; chk_pending = 1'b0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_sof = 1'b0;
    rd_addr = '0; frame_pop = 1'b0;

    //             seed   junk abandon occ ready err
    vecs[0] = '{8'h00, 0, 0,  1, 1'b1, 0};
    vecs[1] = '{8'hA0, 5, 0,  2, 1'b1, 0};
    vecs[2] = '{8'h55, 0, 20, 3, 1'b1, 1};
    vecs[3] = '{8'h10, 0, 0,  4, 1'b1, 1};
    vecs[4] = '{8'h20, 3, 0,  5, 1'b1, 1};
    vecs[5] = '{8'h30, 0, 0,  6, 1'b1, 1};
    vecs[6] = '{8'h40, 0, 7,  7, 1'b1, 2};
    vecs[7] = '{8'h50, 0, 0,  8, 1'b0, 2};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_frame_avail", frame_avail, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_err_sof", err_sof, 0);

    // Fill all eight slots without popping.
    for (int k = 0; k < 8; k++) begin
      send_junk(vecs[k].junk);
      send_partial(vecs[k].abandon);
      send_frame(vecs[k].seed);
      @(negedge clk);
      check($sformatf("fill%0d_occupancy", k), occupancy, vecs[k].exp_occ);
      check($sformatf("fill%0d_in_ready", k), in_ready, vecs[k].exp_ready);
      check($sformatf("fill%0d_frame_avail", k), frame_avail, 1);
      check($sformatf("fill%0d_err_count", k), err_cnt, vecs[k].exp_err);
      if (k == 0) read_frame(8'h00);
    end

    // Ninth frame offered while full must be ignored.
    in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      in_sof  = (i == 0);
      in_data = 8'h99;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    check("full_occupancy", occupancy, 8);
    check("full_in_ready", in_ready, 0);
    check("full_err_count", err_cnt, 2);

    pop_head();
    check("pop_in_ready", in_ready, 1);
    check("pop_occupancy", occupancy, 7);
    read_frame(8'hA0);
    pop_head();
    read_frame(8'h55);
    pop_head(); pop_head(); pop_head();
    check("pre_cp_occupancy", occupancy, 3);

    // Last byte of a frame accepted on the same edge as a pop.
    for (int i = 0; i < 63; i++) send_byte(8'(8'h77 + i), (i == 0));
    check("cp_in_ready", in_ready, 1);
    in_valid  = 1'b1;
    in_data   = 8'(8'h77 + 63);
    frame_pop = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    frame_pop = 1'b0;
    check("cp_occupancy", occupancy, 3);
    read_frame(8'h40);
    pop_head(); pop_head();
    check("cp_tail_occupancy", occupancy, 1);
    read_frame(8'h77);

    // Flush in the middle of a frame with two frames held.
    send_frame(8'h88);
    @(negedge clk);
    check("pre_flush_occupancy", occupancy, 2);
    send_partial(10);
    e0 = err_cnt;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_occupancy", occupancy, 0);
    check("flush_frame_avail", frame_avail, 0);
    check("flush_in_ready", in_ready, 1);
    send_junk(3);
    send_frame(8'h99);
    @(negedge clk); @(negedge clk);
    check("flush_err_count", err_cnt, e0);
    check("post_flush_occupancy", occupancy, 1);
    read_frame(8'h99);

    // Reset in the middle of a frame.
    send_partial(10);
    e0 = err_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_rd_data", rd_data, 8'h00);
    check("mid_rst_occupancy", occupancy, 0);
    check("mid_rst_frame_avail", frame_avail, 0);
    check("mid_rst_in_ready", in_ready, 1);
    send_junk(2);
    send_frame(8'hC0);
    @(negedge clk); @(negedge clk);
    check("mid_rst_err_count", err_cnt, e0);
    check("post_rst_occupancy", occupancy, 1);
    read_frame(8'hC0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
